// File: rtl/focus_pkg.sv
// focus_pkg: shared constants and types for the focus statistics path.
// Window defaults are shared with the VCM step controller.
package focus_pkg;

    localparam int LUMA_R = 77;
    localparam int LUMA_G = 150;
    localparam int LUMA_B = 29;

    localparam int SUM_W_DEF   = 32;
    localparam int CORE_TH_DEF = 4;

    localparam int WIN_H_START = 320;
    localparam int WIN_H_SIZE  = 640;
    localparam int WIN_V_START = 180;
    localparam int WIN_V_SIZE  = 360;

    localparam int CNT_W  = 16;
    localparam int PCNT_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LATCH = 2'd2
    } frame_st_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/focus_luma_grad.sv
// focus_luma_grad: stage 1 luma, stage 2 absolute horizontal gradient.
// Optional coring under macro FOCUS_STAT_CORING_EN (compare lives in stage 2).
module focus_luma_grad
    import focus_pkg::*;
#(
    parameter int CORE_TH = CORE_TH_DEF
) (
    input  logic       VIDEO_CLK,
    input  logic       RESET,
    input  logic       de,
    input  logic       line_first,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] grad,
    output logic       de_q
);

`ifdef FOCUS_STAT_CORING_EN
    localparam bit CORE_EN = 1'b1;
`else
    localparam bit CORE_EN = 1'b0;
`endif

    logic [15:0] y_mac;
    logic [7:0]  y_next;
    logic [7:0]  y1;
    logic [7:0]  y_prev;
    logic        de1;
    logic        first1;
    logic [7:0]  g_abs;
    logic [7:0]  g_raw;
    logic [7:0]  g_out;

    assign y_mac  = 16'(LUMA_R) * {8'd0, r}
                  + 16'(LUMA_G) * {8'd0, g}
                  + 16'(LUMA_B) * {8'd0, b};
    assign y_next = 8'(y_mac >> 8);

    // Stage 1: register luma with its DE and line-start tags.
    always_ff @(posedge VIDEO_CLK or posedge RESET) begin
        if (RESET) begin
            y1     <= '0;
            de1    <= 1'b0;
            first1 <= 1'b0;
        end else begin
            y1     <= y_next;
            de1    <= de;
            first1 <= line_first;
        end
    end

    // Absolute difference, masked at line start, optionally cored.
    always_comb begin
        g_abs = '0;
        g_raw = '0;
        g_out = '0;
        g_abs = (y1 >= y_prev) ? (y1 - y_prev) : (y_prev - y1);
        g_raw = first1 ? 8'd0 : g_abs;
        g_out = (CORE_EN && (g_raw <= 8'(CORE_TH))) ? 8'd0 : g_raw;
    end

    // Stage 2: register gradient and remember the last DE luma.
    always_ff @(posedge VIDEO_CLK or posedge RESET) begin
        if (RESET) begin
            y_prev <= '0;
            grad   <= '0;
            de_q   <= 1'b0;
        end else begin
            if (de1) begin
                y_prev <= y1;
            end
            grad <= de1 ? g_out : 8'd0;
            de_q <= de1;
        end
    end

endmodule

// File: rtl/focus_sharp_stat.sv
// focus_sharp_stat: per-frame windowed gradient sum for autofocus.
// Optional coring under macro FOCUS_STAT_CORING_EN (see focus_luma_grad).
module focus_sharp_stat
    import focus_pkg::*;
#(
    parameter int H_START = WIN_H_START,
    parameter int H_SIZE  = WIN_H_SIZE,
    parameter int V_START = WIN_V_START,
    parameter int V_SIZE  = WIN_V_SIZE,
    parameter int SUM_W   = SUM_W_DEF,
    parameter int CORE_TH = CORE_TH_DEF
) (
    input  logic              VIDEO_CLK,
    input  logic              RESET,
    input  logic              VIDEO_VS,
    input  logic              VIDEO_HS,
    input  logic              VIDEO_DE,
    input  logic [7:0]        iR,
    input  logic [7:0]        iG,
    input  logic [7:0]        iB,
    output logic [7:0]        GRAD,
    output logic [SUM_W-1:0]  SHARP_SUM,
    output logic [PCNT_W-1:0] PIX_CNT,
    output logic              SHARP_VALID,
    output logic              IN_WIN
);

    logic              hs_d, vs_d;
    logic              hs_fall, vs_fall;
    logic              line_open, first_de;
    logic [CNT_W-1:0]  col_cnt, col_cur;
    logic [CNT_W-1:0]  line_cnt, line_base, line_nxt;
    logic              win0, win1, win2;
    logic              de_q;
    logic              first_frame;
    logic              do_acc;
    frame_st_t         state, state_nxt;
    logic [SUM_W-1:0]  acc, acc_base, acc_nxt;
    logic [SUM_W:0]    acc_add;
    logic [PCNT_W-1:0] pcnt, pcnt_base, pcnt_nxt;

    focus_luma_grad #(.CORE_TH(CORE_TH)) u_lg (
        .VIDEO_CLK  (VIDEO_CLK),
        .RESET      (RESET),
        .de         (VIDEO_DE),
        .line_first (first_de),
        .r          (iR),
        .g          (iG),
        .b          (iB),
        .grad       (GRAD),
        .de_q       (de_q)
    );

    assign IN_WIN = win2;

    // Sync edges, pixel position of the incoming pixel and window test.
    always_comb begin
        hs_fall   = hs_d & ~VIDEO_HS;
        vs_fall   = vs_d & ~VIDEO_VS;
        col_cur   = hs_fall ? '0 : col_cnt;
        first_de  = VIDEO_DE & (hs_fall | ~line_open);
        line_base = vs_fall ? '0 : line_cnt;
        line_nxt  = first_de ? sat_inc(line_base) : line_base;
        win0      = VIDEO_DE
                  && (int'(col_cur) >= H_START)
                  && (int'(col_cur) < H_START + H_SIZE)
                  && (int'(line_nxt) >= V_START + 1)
                  && (int'(line_nxt) < V_START + V_SIZE + 1);
    end

    // Column/line counters and sync edge history.
    always_ff @(posedge VIDEO_CLK or posedge RESET) begin
        if (RESET) begin
            hs_d      <= 1'b0;
            vs_d      <= 1'b0;
            line_open <= 1'b0;
            col_cnt   <= '0;
            line_cnt  <= '0;
        end else begin
            hs_d      <= VIDEO_HS;
            vs_d      <= VIDEO_VS;
            line_open <= hs_fall ? VIDEO_DE : (line_open | VIDEO_DE);
            col_cnt   <= VIDEO_DE ? sat_inc(col_cur) : col_cur;
            line_cnt  <= line_nxt;
        end
    end

    // Window flag delayed in step with the luma/gradient pipeline.
    always_ff @(posedge VIDEO_CLK or posedge RESET) begin
        if (RESET) begin
            win1 <= 1'b0;
            win2 <= 1'b0;
        end else begin
            win1 <= win0;
            win2 <= win1;
        end
    end

    // Frame FSM next state plus saturating accumulate with latch carry.
    always_comb begin
        state_nxt = state;
        acc_base  = (state == ST_LATCH) ? '0 : acc;
        pcnt_base = (state == ST_LATCH) ? '0 : pcnt;
        do_acc    = de_q & win2 & (state != ST_IDLE);
        acc_add   = {1'b0, acc_base} + {{(SUM_W-7){1'b0}}, GRAD};
        acc_nxt   = acc_base;
        pcnt_nxt  = pcnt_base;
        if (do_acc) begin
            acc_nxt  = acc_add[SUM_W] ? '1 : acc_add[SUM_W-1:0];
            pcnt_nxt = (&pcnt_base) ? pcnt_base : pcnt_base + PCNT_W'(1);
        end
        unique case (state)
            ST_IDLE:  if (vs_fall) state_nxt = ST_RUN;
            ST_RUN:   if (vs_fall) state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, accumulators and published frame results.
    always_ff @(posedge VIDEO_CLK or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            first_frame <= 1'b1;
            acc         <= '0;
            pcnt        <= '0;
            SHARP_SUM   <= '0;
            PIX_CNT     <= '0;
            SHARP_VALID <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            pcnt        <= pcnt_nxt;
            SHARP_VALID <= 1'b0;
            if (state == ST_IDLE && vs_fall) begin
                first_frame <= 1'b0;
            end
            if (state == ST_LATCH) begin
                SHARP_SUM   <= acc;
                PIX_CNT     <= pcnt;
                SHARP_VALID <= ~first_frame;
            end
        end
    end

endmodule

// File: tb/tb_focus_sharp_stat.sv
// tb_focus_sharp_stat: directed frames on a reduced 16x10 raster.
// Window cols 4..11, lines 2..5; second instance uses a 12-bit sum.
module tb_focus_sharp_stat;

    localparam int FW  = 16;
    localparam int FH  = 10;
    localparam int HS0 = 4;
    localparam int HSZ = 8;
    localparam int VS0 = 2;
    localparam int VSZ = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs  = 1'b1;
    logic        hs  = 1'b1;
    logic        de  = 1'b0;
    logic [7:0]  r   = '0;
    logic [7:0]  g   = '0;
    logic [7:0]  b   = '0;

    logic [7:0]  grad;
    logic [31:0] sum;
    logic [19:0] cnt;
    logic        valid;
    logic        in_win;
    logic [7:0]  s_grad;
    logic [11:0] s_sum;
    logic [19:0] s_cnt;
    logic        s_valid;
    logic        s_in_win;

    int total = 0;
    int bad   = 0;

    logic cur_de = 1'b0;
    int   cur_line = 0;
    int   cur_col  = 0;
    logic p0_de = 1'b0, p1_de = 1'b0;
    int   p0_l = 0, p0_c = 0, p1_l = 0, p1_c = 0;
    logic [7:0] grad_log [FH][FW];
    logic       win_log  [FH][FW];
    int          vtotal = 0;
    logic [31:0] last_sum = '0;
    logic [19:0] last_cnt = '0;
    logic [11:0] last_sum_s = '0;
    logic [19:0] last_cnt_s = '0;

    always #5 clk = ~clk;

    focus_sharp_stat #(
        .H_START(HS0), .H_SIZE(HSZ), .V_START(VS0), .V_SIZE(VSZ),
        .SUM_W(32), .CORE_TH(4)
    ) dut (
        .VIDEO_CLK(clk), .RESET(rst), .VIDEO_VS(vs), .VIDEO_HS(hs),
        .VIDEO_DE(de), .iR(r), .iG(g), .iB(b), .GRAD(grad),
        .SHARP_SUM(sum), .PIX_CNT(cnt), .SHARP_VALID(valid),
        .IN_WIN(in_win)
    );

    focus_sharp_stat #(
        .H_START(HS0), .H_SIZE(HSZ), .V_START(VS0), .V_SIZE(VSZ),
        .SUM_W(12), .CORE_TH(4)
    ) dut_s (
        .VIDEO_CLK(clk), .RESET(rst), .VIDEO_VS(vs), .VIDEO_HS(hs),
        .VIDEO_DE(de), .iR(r), .iG(g), .iB(b), .GRAD(s_grad),
        .SHARP_SUM(s_sum), .PIX_CNT(s_cnt), .SHARP_VALID(s_valid),
        .IN_WIN(s_in_win)
    );

    // Tag pipeline two cycles deep: logs GRAD/IN_WIN per raster position.
    always @(negedge clk) begin
        if (p1_de && p1_l >= 0 && p1_l < FH && p1_c >= 0 && p1_c < FW) begin
            grad_log[p1_l][p1_c] <= grad;
            win_log[p1_l][p1_c]  <= in_win;
        end
        p1_de <= p0_de;
        p1_l  <= p0_l;
        p1_c  <= p0_c;
        p0_de <= cur_de;
        p0_l  <= cur_line;
        p0_c  <= cur_col;
        if (valid) begin
            vtotal   <= vtotal + 1;
            last_sum <= sum;
            last_cnt <= cnt;
        end
        if (s_valid) begin
            last_sum_s <= s_sum;
            last_cnt_s <= s_cnt;
        end
    end

    function automatic logic [23:0] pix(input int p, input int l, input int c);
        logic [7:0] v;
        v = 8'(3 * c);
        case (p)
            0: return {3{8'd128}};
            1: return (c % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            2: return (l == 2 && c == 4) ? 24'hFFFFFF : 24'h000000;
            3: return (l == 2 && c == 3) ? 24'hFFFFFF : 24'h000000;
            4: return {v, v, v};
            5: begin
                if (l == 2 && c == 4) return 24'hFF0000;
                if (l == 2 && c == 6) return 24'h00FF00;
                if (l == 2 && c == 8) return 24'h0000FF;
                return 24'h000000;
            end
            default: return 24'h000000;
        endcase
    endfunction

    task automatic drive(input logic v, input logic h, input logic d,
                         input logic [23:0] rgb, input int l, input int c);
        @(posedge clk);
        #1;
        vs = v; hs = h; de = d;
        r = rgb[23:16]; g = rgb[15:8]; b = rgb[7:0];
        cur_de = d; cur_line = l; cur_col = c;
    endtask

    task automatic send_line(input int p, input int l);
        for (int i = 0; i < 2; i++) drive(1, 0, 0, 24'h0, l, 0);
        for (int i = 0; i < 2; i++) drive(1, 1, 0, 24'h0, l, 0);
        for (int c = 0; c < FW; c++) drive(1, 1, 1, pix(p, l, c), l, c);
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 24'h0, l, 0);
    endtask

    task automatic send_frame(input int p);
        for (int l = 0; l < FH; l++) send_line(p, l);
    endtask

    task automatic vs_pulse();
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 24'h0, 0, 0);
        for (int i = 0; i < 8; i++) drive(1, 1, 0, 24'h0, 0, 0);
    endtask

    task automatic test_reset();
        int v0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (grad !== 8'd0) begin bad++; $display("FAIL rst_grad got=%0d want=0", grad); end
        total++; if (sum !== 32'd0) begin bad++; $display("FAIL rst_sum got=%0d want=0", sum); end
        total++; if (cnt !== 20'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", cnt); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d want=0", valid); end
        total++; if (in_win !== 1'b0) begin bad++; $display("FAIL rst_inwin got=%0d want=0", in_win); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        v0 = vtotal;
        vs_pulse();
        total++; if (vtotal !== v0) begin bad++; $display("FAIL first_vs_valid got=%0d want=0", vtotal - v0); end
    endtask

    task automatic test_flat();
        int v0;
        v0 = vtotal;
        send_frame(0);
        vs_pulse();
        total++; if (vtotal - v0 !== 1) begin bad++; $display("FAIL flat_nvalid got=%0d want=1", vtotal - v0); end
        total++; if (last_sum !== 32'd0) begin bad++; $display("FAIL flat_sum got=%0d want=0", last_sum); end
        total++; if (last_cnt !== 20'd32) begin bad++; $display("FAIL flat_cnt got=%0d want=32", last_cnt); end
        total++; if (grad_log[3][7] !== 8'd0) begin bad++; $display("FAIL flat_grad got=%0d want=0", grad_log[3][7]); end
    endtask

    task automatic test_stripes();
        int v0;
        v0 = vtotal;
        send_frame(1);
        vs_pulse();
        total++; if (vtotal - v0 !== 1) begin bad++; $display("FAIL str_nvalid got=%0d want=1", vtotal - v0); end
        total++; if (last_sum !== 32'd8160) begin bad++; $display("FAIL str_sum got=%0d want=8160", last_sum); end
        total++; if (last_cnt !== 20'd32) begin bad++; $display("FAIL str_cnt got=%0d want=32", last_cnt); end
        total++; if (last_sum_s !== 12'hFFF) begin bad++; $display("FAIL str_sat_sum got=%0d want=4095", last_sum_s); end
        total++; if (last_cnt_s !== 20'd32) begin bad++; $display("FAIL str_sat_cnt got=%0d want=32", last_cnt_s); end
        total++; if (grad_log[3][0] !== 8'd0) begin bad++; $display("FAIL str_first_grad got=%0d want=0", grad_log[3][0]); end
        total++; if (grad_log[3][1] !== 8'd255) begin bad++; $display("FAIL str_grad1 got=%0d want=255", grad_log[3][1]); end
        total++; if (win_log[2][4] !== 1'b1) begin bad++; $display("FAIL win_2_4 got=%0d want=1", win_log[2][4]); end
        total++; if (win_log[2][3] !== 1'b0) begin bad++; $display("FAIL win_2_3 got=%0d want=0", win_log[2][3]); end
        total++; if (win_log[1][4] !== 1'b0) begin bad++; $display("FAIL win_1_4 got=%0d want=0", win_log[1][4]); end
        total++; if (win_log[5][11] !== 1'b1) begin bad++; $display("FAIL win_5_11 got=%0d want=1", win_log[5][11]); end
        total++; if (win_log[6][11] !== 1'b0) begin bad++; $display("FAIL win_6_11 got=%0d want=0", win_log[6][11]); end
        total++; if (win_log[2][12] !== 1'b0) begin bad++; $display("FAIL win_2_12 got=%0d want=0", win_log[2][12]); end
    endtask

    task automatic test_single();
        send_frame(2);
        vs_pulse();
        total++; if (last_sum !== 32'd510) begin bad++; $display("FAIL px_sum got=%0d want=510", last_sum); end
        total++; if (grad_log[2][5] !== 8'd255) begin bad++; $display("FAIL px_grad5 got=%0d want=255", grad_log[2][5]); end
        total++; if (grad_log[2][6] !== 8'd0) begin bad++; $display("FAIL px_grad6 got=%0d want=0", grad_log[2][6]); end
        send_frame(3);
        vs_pulse();
        total++; if (last_sum !== 32'd255) begin bad++; $display("FAIL px_edge_sum got=%0d want=255", last_sum); end
        total++; if (last_cnt !== 20'd32) begin bad++; $display("FAIL px_edge_cnt got=%0d want=32", last_cnt); end
    endtask

    task automatic test_color();
        send_frame(5);
        vs_pulse();
        total++; if (grad_log[2][4] !== 8'd76) begin bad++; $display("FAIL col_r got=%0d want=76", grad_log[2][4]); end
        total++; if (grad_log[2][6] !== 8'd149) begin bad++; $display("FAIL col_g got=%0d want=149", grad_log[2][6]); end
        total++; if (grad_log[2][8] !== 8'd28) begin bad++; $display("FAIL col_b got=%0d want=28", grad_log[2][8]); end
        total++; if (last_sum !== 32'd506) begin bad++; $display("FAIL col_sum got=%0d want=506", last_sum); end
    endtask

    task automatic test_mid_reset();
        int v0;
        for (int l = 0; l < 4; l++) send_line(1, l);
        v0 = vtotal;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (sum !== 32'd0) begin bad++; $display("FAIL mr_sum got=%0d want=0", sum); end
        total++; if (cnt !== 20'd0) begin bad++; $display("FAIL mr_cnt got=%0d want=0", cnt); end
        rst = 1'b0;
        for (int l = 4; l < FH; l++) send_line(1, l);
        vs_pulse();
        total++; if (vtotal !== v0) begin bad++; $display("FAIL mr_novalid got=%0d want=0", vtotal - v0); end
        send_frame(2);
        vs_pulse();
        total++; if (vtotal - v0 !== 1) begin bad++; $display("FAIL mr_nvalid got=%0d want=1", vtotal - v0); end
        total++; if (last_sum !== 32'd510) begin bad++; $display("FAIL mr_sum2 got=%0d want=510", last_sum); end
        total++; if (last_cnt !== 20'd32) begin bad++; $display("FAIL mr_cnt2 got=%0d want=32", last_cnt); end
    endtask

    task automatic test_ramp_empty();
        int v0;
        int exp_sum;
`ifdef FOCUS_STAT_CORING_EN
        exp_sum = 0;
`else
        exp_sum = 96;
`endif
        send_frame(4);
        vs_pulse();
        total++; if (last_sum !== 32'(exp_sum)) begin bad++; $display("FAIL ramp_sum got=%0d want=%0d", last_sum, exp_sum); end
        v0 = vtotal;
        vs_pulse();
        total++; if (vtotal - v0 !== 1) begin bad++; $display("FAIL empty_nvalid got=%0d want=1", vtotal - v0); end
        total++; if (last_sum !== 32'd0) begin bad++; $display("FAIL empty_sum got=%0d want=0", last_sum); end
        total++; if (last_cnt !== 20'd0) begin bad++; $display("FAIL empty_cnt got=%0d want=0", last_cnt); end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_stripes();
        test_single();
        test_color();
        test_mid_reset();
        test_ramp_empty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/focus_sharp_stat.md
Name: focus_sharp_stat

Overview:
- Per-frame sharpness statistic engine that sits directly upstream of the autofocus VCM step controller.
- Converts incoming RGB video to luma and accumulates the absolute horizontal luma gradient over a programmable centre window.
- Publishes one sharpness figure per frame with a valid pulse; the hill-climb focus search consumes it to choose the next VCM step.
- Also exports the per-pixel gradient so the video mixer can display the high-frequency view.

Parameters:
- H_START, 320, first active pixel column (0-based) inside the window
- H_SIZE, 640, window width in pixels
- V_START, 180, first active line (0-based) inside the window
- V_SIZE, 360, window height in lines
- SUM_W, 32, accumulator and SHARP_SUM width
- CORE_TH, 4, coring threshold (used only with the optional feature)

Ports:
- VIDEO_CLK  in  1  pixel clock
- RESET  in  1  asynchronous, active-high reset
- VIDEO_VS  in  1  vertical sync, already normalised to negative pulse
- VIDEO_HS  in  1  horizontal sync, already normalised to negative pulse
- VIDEO_DE  in  1  active-pixel qualifier
- iR / iG / iB  in  8 each  pixel colour
- GRAD  out  8  registered per-pixel gradient, for display
- SHARP_SUM  out  SUM_W  last completed frame's window gradient sum
- PIX_CNT  out  20  window pixels counted in the last frame
- SHARP_VALID  out  1  one-cycle pulse when SHARP_SUM and PIX_CNT update
- IN_WIN  out  1  current pixel (pipeline-aligned with GRAD) lies inside the window

Behaviour:
- Reset values: all outputs 0; accumulator, counters and pipeline cleared; first-frame flag set.
- Stage 1 (luma): Y = (77*R + 150*G + 29*B) >> 8, 8 bits unsigned, registered. The 16-bit intermediate never overflows, since the weights sum to 256.
- Stage 2 (gradient): GRAD = |Y - Yprev|, registered.
  - Yprev is the previous DE pixel on the same line.
  - The first DE pixel of each line gives GRAD = 0.
- Total latency from input pixel to GRAD/IN_WIN: 2 cycles. DE, HS and window flags are delayed in step with the data.
- Column counter: counts DE pixels; cleared on each HS falling edge (edge detected with a registered copy of HS).
- Line counter: increments on the first DE of a line; cleared on each VS falling edge.
- Window test: IN_WIN = 1 iff H_START <= col < H_START+H_SIZE and V_START <= line < V_START+V_SIZE.
  - Counters saturate at all-ones and never wrap back into the window.
- Accumulate: when the delayed DE and IN_WIN are both 1, acc += GRAD and pcnt += 1.
  - acc saturates at 2^SUM_W - 1.
  - pcnt saturates at 2^20 - 1.
- Frame FSM, states IDLE -> RUN -> LATCH -> RUN:
  - IDLE: after reset; the first VS falling edge moves to RUN without publishing and clears the first-frame flag.
  - RUN: accumulate. On a VS falling edge, go to LATCH.
  - LATCH (1 cycle): SHARP_SUM <= acc, PIX_CNT <= pcnt, SHARP_VALID = 1, acc and pcnt cleared; return to RUN.
- Simultaneous events:
  - A pixel accumulated in the same cycle as the LATCH clear is carried into the new frame, not lost.
  - Video timing guarantees DE is low for at least 3 cycles before VS falls; a violation only mis-assigns those pixels.
- A frame with zero window pixels still publishes SUM = 0, CNT = 0 with SHARP_VALID.
- Reset mid-frame: everything returns to IDLE. The partial frame is discarded and no SHARP_VALID is produced for it.

Optional Feature:
- Macro FOCUS_STAT_CORING_EN.
- Defined: gradients <= CORE_TH are forced to 0 before both GRAD and accumulation, suppressing sensor noise. Latency is unchanged, because the compare sits in stage 2.
- Undefined: no coring; CORE_TH is ignored.

Decomposition:
- Shared package focus_pkg holds:
  - luma coefficients (77/150/29)
  - SUM_W default
  - frame-FSM state encoding (IDLE/RUN/LATCH)
  - the window default constants shared with the VCM step controller
- One natural sub-module: focus_luma_grad (stages 1–2: luma plus absolute difference with line-start masking).
- Counters, window test and FSM stay in the top.

Test Plan:
- Flat grey frame (R=G=B=128), 1280x720, default window -> GRAD = 0 everywhere; second VS gives SHARP_SUM = 0, PIX_CNT = 230400, one SHARP_VALID.
- Vertical stripes alternating 0/255 each pixel -> GRAD = 255 in the window; SHARP_SUM = 255*230400 = 58752000; the first pixel of each line gives GRAD = 0.
- Single pixel of 255 at (col 320, line 180) on black -> SHARP_SUM = 510. A pixel at col 319 gives 255, because only its right neighbour is in-window.
- SUM_W = 16 with the stripe frame -> SHARP_SUM = 0xFFFF (saturated); PIX_CNT still 230400.
- RESET pulse mid-frame, then two full frames -> no SHARP_VALID until the second VS falling edge after reset; its values match a clean single frame.
- With FOCUS_STAT_CORING_EN and a ramp of step 3 -> SHARP_SUM = 0. Without the macro -> SHARP_SUM = 3*(pixels with in-line predecessor).
